// File: rtl/mux4_pkg.sv
// Shared definitions for the four-source round-robin operand selector:
// select codes, the output-register state encoding and a select decoder.
package mux4_pkg;

  localparam int NUM_SRC = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // EMPTY: out_data holds nothing useful; FULL: out_data awaits the consumer.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Turn a select code into the matching one-hot grant vector.
  function automatic logic [NUM_SRC-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: returns the first requesting index
// found when scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  output logic               any,
  output logic [1:0]         idx
);

  logic [1:0] cand_idx [NUM_SRC];
  logic [NUM_SRC-1:0] cand_hit;

  // Candidate gi is the source sitting gi places after the pointer.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      assign cand_idx[gi] = ptr + 2'(gi);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the candidate closest to the pointer wins.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        any = 1'b1;
        idx = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin sharing of one 4:1 select datapath between sources A..D.
// The selected word is captured into an output register that is drained
// by the consumer through a valid/ready handshake; a new word can be
// captured on the same edge the old one is accepted (1 word/cycle).
module mux4_rr_arbiter
  import mux4_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  req,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    c,
  input  logic [WIDTH-1:0]    d,
  output logic [NUM_SRC-1:0]  gnt,
  output logic [1:0]          op,
  output logic [WIDTH-1:0]    out_data,
  output logic [1:0]          out_src,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    xfer_cnt
);

  state_e               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [1:0]           out_src_q, out_src_d;
  logic [NUM_SRC-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]     xfer_cnt_q, xfer_cnt_d;

  logic                 pick_any;
  logic [1:0]           pick_idx;
  logic [1:0]           op_sel;
  logic [WIDTH-1:0]     sel_word;
  logic                 valid;
  logic                 free;
  logic                 capture;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign valid = (state_q == ST_FULL);

  // The output register can take a word when it is empty or being drained.
  assign free    = !valid || out_ready;
  assign capture = free && pick_any;

  // With nobody requesting, the select stays parked on the held word's source.
  assign op_sel = pick_any ? pick_idx : out_src_q;

  // Shared 4:1 datapath driven by the current select code.
  always_comb begin
    sel_word = a;
    case (op_sel)
      SEL_A:   sel_word = a;
      SEL_B:   sel_word = b;
      SEL_C:   sel_word = c;
      SEL_D:   sel_word = d;
      default: sel_word = a;
    endcase
  end

  // Next-state logic: handshake bookkeeping plus capture of the picked word.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    gnt_d      = '0;
    xfer_cnt_d = xfer_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (capture) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          // Consumer takes the held word; counter wraps silently.
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
          if (!capture) begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (capture) begin
      out_data_d = sel_word;
      out_src_d  = op_sel;
      gnt_d      = sel_onehot(op_sel);
      ptr_d      = op_sel + 2'd1;
    end
  end

  // State register; reset drops any held word and suppresses the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= SEL_A;
      out_data_q <= '0;
      out_src_q  <= SEL_A;
      gnt_q      <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      gnt_q      <= gnt_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign op        = op_sel;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = valid;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
